// File: rtl/fmin_stream_reduce.sv
// ---------------------------------------------------------------------------
// fmin_stream_reduce
//   Sequential IEEE-754 binary32 minimum reducer. Operands arrive over a
//   valid/ready stream, and in_last ends each burst. One result is emitted
//   per burst. The result holds the minimum value and the element count.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand valid
//   in_ready   block can accept an operand (low while a result is pending)
//   in_data    binary32 operand
//   in_last    final operand of the burst (qualified by in_valid)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   burst minimum, or canonical qNaN 0x7FC00000 if any NaN was seen
//   out_count  operands accepted in the burst, saturating at 2^COUNT_W-1
//
// Optional build macro
//   FMIN_FLUSH_DENORM_EN : flush subnormal operands to a zero of the same
//                          sign before compare/store.
//
// state | meaning
// IDLE  | waiting for the first operand of a burst
// ACCUM | folding further operands into the running minimum
// HOLD  | result presented, waiting for out_ready
// ---------------------------------------------------------------------------
module fmin_stream_reduce #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [COUNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [31:0]        QNAN    = 32'h7FC0_0000;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  state_t             state_q, state_d;
  logic [31:0]        acc_q, acc_d;
  logic               nan_q, nan_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic               in_xfer;
  logic               out_xfer;
  logic [31:0]        op;
  logic               op_nan;
  logic [COUNT_W-1:0] cnt_inc;

  function automatic logic [31:0] flush_op(input logic [31:0] x);
`ifdef FMIN_FLUSH_DENORM_EN
    if (x[30:23] == 8'h00) return {x[31], 31'b0};
    else                   return x;
`else
    return x;
`endif
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'b0);
  endfunction

  // Strict a < b on non-NaN encodings; the sign/magnitude compare also
  // puts -0 below +0. Equal values report 0, so the accumulator is kept.
  function automatic logic f_lt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return a[31];
    else if (!a[31])    return a[30:0] < b[30:0];
    else                return a[30:0] > b[30:0];
  endfunction

  assign op       = flush_op(in_data);
  assign op_nan   = is_nan(in_data);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 32'b0;
      nan_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      nan_q   <= nan_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    nan_d   = nan_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_xfer) begin
          acc_d   = op;
          nan_d   = op_nan;
          cnt_d   = CNT_ONE;
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (in_xfer) begin
          if (f_lt(op, acc_q)) acc_d = op;
          nan_d = nan_q | op_nan;
          cnt_d = cnt_inc;
          if (in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    out_data  = 32'b0;
    out_count = '0;
    if (state_q == HOLD) begin
      in_ready  = 1'b0;
      out_valid = 1'b1;
      out_data  = nan_q ? QNAN : acc_q;
      out_count = cnt_q;
    end
  end

endmodule

// File: tb/tb_fmin_stream_reduce.sv
module tb_fmin_stream_reduce;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [CW-1:0] out_count;

  int n_tests = 0;
  int n_fail  = 0;

  fmin_stream_reduce #(.COUNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][31:0] d;
    int               n;
    logic [31:0]      exp_d;
    logic [CW-1:0]    exp_c;
    string            name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 32'hDEAD_BEEF;
  endtask

  // Called right after the last operand is accepted: result must already be valid.
  task automatic expect_result(input string name, input logic [31:0] ed, input logic [CW-1:0] ec);
    check({name, ".valid"}, 64'(out_valid), 64'(1'b1));
    check({name, ".data"},  64'(out_data),  64'(ed));
    check({name, ".count"}, 64'(out_count), 64'(ec));
    out_ready = 1'b1;
    tick();
    check({name, ".idle"}, 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  initial begin
    vecs[0] = '{d: '{32'h0, 32'h3F000000, 32'hBF800000, 32'h40400000}, n: 3, exp_d: 32'hBF800000, exp_c: 3, name: "mixed"};
    vecs[1] = '{d: '{32'h0, 32'hC0000000, 32'h7F800001, 32'h3F800000}, n: 3, exp_d: 32'h7FC00000, exp_c: 3, name: "nan_mid"};
    vecs[2] = '{d: '{32'h0, 32'h0, 32'h80000000, 32'h00000000}, n: 2, exp_d: 32'h80000000, exp_c: 2, name: "pz_nz"};
    vecs[3] = '{d: '{32'h0, 32'h0, 32'h00000000, 32'h80000000}, n: 2, exp_d: 32'h80000000, exp_c: 2, name: "nz_pz"};
    vecs[4] = '{d: '{32'h0, 32'h0, 32'hC2C80000, 32'hFF800000}, n: 2, exp_d: 32'hFF800000, exp_c: 2, name: "neg_inf"};
    vecs[5] = '{d: '{32'h0, 32'h0, 32'h0, 32'h7FA00000}, n: 1, exp_d: 32'h7FC00000, exp_c: 1, name: "single_nan"};
    vecs[6] = '{d: '{32'h0, 32'hC0200000, 32'hC0400000, 32'hC0000000}, n: 3, exp_d: 32'hC0400000, exp_c: 3, name: "all_neg"};
    vecs[7] = '{d: '{32'h0, 32'h0, 32'h3F800000, 32'h3F800000}, n: 2, exp_d: 32'h3F800000, exp_c: 2, name: "equal"};
    vecs[8] = '{d: '{32'h0, 32'h0, 32'h00000000, 32'hFFC00001}, n: 2, exp_d: 32'h7FC00000, exp_c: 2, name: "nan_first"};
`ifdef FMIN_FLUSH_DENORM_EN
    vecs[9] = '{d: '{32'h0, 32'h0, 32'h80000001, 32'h00000001}, n: 2, exp_d: 32'h80000000, exp_c: 2, name: "denorm"};
`else
    vecs[9] = '{d: '{32'h0, 32'h0, 32'h80000001, 32'h00000001}, n: 2, exp_d: 32'h80000001, exp_c: 2, name: "denorm"};
`endif

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset.valid", 64'(out_valid), 64'(1'b0));
    check("reset.ready", 64'(in_ready),  64'(1'b1));
    check("reset.data",  64'(out_data),  64'(32'h0));
    check("reset.count", 64'(out_count), 64'(0));

    // Table-driven bursts; d[] is packed MSB-first, operand i is d[n-1-i]
    foreach (vecs[v]) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        check({vecs[v].name, ".busy"}, 64'({out_valid, in_ready}), 64'(2'b01));
        push(vecs[v].d[vecs[v].n-1-i], i == vecs[v].n-1);
      end
      expect_result(vecs[v].name, vecs[v].exp_d, vecs[v].exp_c);
    end

    // Backpressure: result held stable, input blocked, stray inputs ignored
    push(32'h41200000, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 32'hFF800000; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp.valid", 64'(out_valid), 64'(1'b1));
      check("bp.ready", 64'(in_ready),  64'(1'b0));
      check("bp.data",  64'(out_data),  64'(32'h41200000));
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    expect_result("bp", 32'h41200000, 1);
    push(32'h7F800000, 1'b1);
    expect_result("after_bp", 32'h7F800000, 1);

    // Idle gap inside a burst; junk on in_data/in_last while in_valid=0
    push(32'h40000000, 1'b0);
    in_data = 32'h80000000; in_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("gap.hold", 64'({out_valid, in_ready}), 64'(2'b01));
      tick();
    end
    push(32'h3F800000, 1'b1);
    expect_result("gap", 32'h3F800000, 2);

    // Reset mid-burst discards the partial result
    push(32'hC1200000, 1'b0);
    push(32'h3F800000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid.state", 64'({out_valid, in_ready}), 64'(2'b01));
    tick();
    check("rst_mid.quiet", 64'(out_valid), 64'(1'b0));
    push(32'h40000000, 1'b1);
    expect_result("rst_mid", 32'h40000000, 1);

    // Reset while holding a result: nothing emitted afterwards
    push(32'h3F800000, 1'b1);
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_hold.state", 64'({out_valid, in_ready}), 64'(2'b01));
    out_ready = 1'b1;

    // Counter saturation: 18 operands, COUNT_W=4 -> 15
    for (int i = 0; i < 18; i++)
      push((i == 17) ? 32'h3F000000 : 32'h3F800000 + 32'(i), i == 17);
    expect_result("sat", 32'h3F000000, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fmin_stream_reduce.md
Name: fmin_stream_reduce

Overview:
- Sequential single-precision (IEEE-754 binary32) minimum reducer. It is the min-direction companion to the team's combinational float max unit.
- Accepts a burst of operands over a valid/ready input stream, terminated by a last flag.
- Emits one result per burst over a valid/ready output stream: the minimum value and the element count.
- Sits after ALU operand fetch and serves vector min-reduction instructions.

Parameters:
- COUNT_W, 16, width of the element counter and of out_count; the counter saturates at 2^COUNT_W-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  32  binary32 operand.
- in_last  input  1  marks the final operand of the burst; qualified by in_valid.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  32  minimum of the burst.
- out_count  output  COUNT_W  number of operands accepted in the burst (saturating).

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; out_valid=0; out_data=0; out_count=0; in_ready=1.
  - Accumulator, NaN flag and counter are cleared.
  - Reset mid-burst or mid-HOLD discards all partial or pending results; nothing is emitted.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- States:
  - IDLE: in_ready=1. On a transfer: acc=in_data, cnt=1. Go to HOLD if in_last, else ACCUM.
  - ACCUM: in_ready=1. On a transfer: acc=min(acc,in_data), cnt=sat(cnt+1). Go to HOLD if in_last.
  - HOLD: in_ready=0; out_valid=1; out_data and out_count are stable until transfer. On transfer, go to IDLE the next cycle.
- Latency:
  - out_valid rises on the cycle after the last operand is accepted.
  - Minimum burst-to-burst turnaround is 1 cycle: accept last, HOLD/transfer, IDLE. Back-to-back throughput is one operand per cycle within a burst.
- min rule (no-NaN case):
  - Signed order: any negative < any positive.
  - Both positive: smaller {exp,mant} wins.
  - Both negative: larger {exp,mant} wins.
  - -0 < +0, so min(+0,-0) = 0x80000000.
  - Bit-identical or equal value: the accumulator is kept.
  - ±inf are ordered normally.
- NaN (exp=0xFF, mant!=0) on any operand sets a sticky nan flag for the burst. The output is then the canonical qNaN 0x7FC00000, regardless of position in the burst.
- A single-element burst returns that element, with NaN canonicalised.
- in_data and in_last are ignored when in_valid=0. An idle in_valid=0 in ACCUM holds state indefinitely.
- The counter saturates; it never wraps.

Optional Feature:
- Macro: FMIN_FLUSH_DENORM_EN.
- Defined: subnormal operands (exp=0, mant!=0) are replaced by a zero of the same sign before comparison and storage. A result can therefore never be subnormal.
- Undefined: subnormals are compared and returned bit-exact.

Test Plan:
- Burst 0x40400000, 0xBF800000, 0x3F000000(last), out_ready=1 -> out_data=0xBF800000, out_count=3, out_valid exactly one cycle after last accept.
- Burst 0x3F800000, 0x7F800001, 0xC0000000(last) -> out_data=0x7FC00000, out_count=3.
- Burst 0x00000000, 0x80000000(last) -> 0x80000000. Burst 0xFF800000, 0xC2C80000(last) -> 0xFF800000.
- Backpressure test:
  - Burst 0x41200000(last), then out_ready=0 for 5 cycles -> out_data=0x41200000 stable, in_ready=0 throughout.
  - Release out_ready -> IDLE; next burst 0x7F800000(last) -> 0x7F800000, count 1.
- Reset mid-burst:
  - Accept 0xC1200000 and 0x3F800000, then rst=1 for 1 cycle -> out_valid=0, in_ready=1.
  - New burst 0x40000000(last) -> 0x40000000, count 1.
- Burst 0x00000001, 0x80000001(last) -> 0x80000000 with FMIN_FLUSH_DENORM_EN defined; 0x80000001 without it.
